// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the oversampled JTAG TAP controller.
package jtag_tap_pkg;

   localparam int unsigned IR_W     = 5;
   localparam int unsigned IDCODE_W = 32;

   localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
   localparam logic [IR_W-1:0] IR_USER    = 5'h10;
   localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;
   localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00001;

   // TAP states, IEEE 1149.1 encoding
   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   // Data register selected by the current instruction
   typedef enum logic [1:0] {
      SEL_IDCODE = 2'd0,
      SEL_USER   = 2'd1,
      SEL_BYPASS = 2'd2
   } dr_sel_e;

   // TAP state transition on a TCK rise
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          n = TEST_LOGIC_RESET;
      endcase
      return n;
   endfunction

   // Unknown instruction codes fall back to BYPASS
   function automatic dr_sel_e dr_decode(input logic [IR_W-1:0] ir);
      dr_sel_e sel;
      case (ir)
         IR_IDCODE: sel = SEL_IDCODE;
         IR_USER:   sel = SEL_USER;
         default:   sel = SEL_BYPASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/jtag_sync.sv
// Parameterized-width 2-flop synchronizer with per-bit reset value.
module jtag_sync #(
   parameter int unsigned     W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two-stage capture of asynchronous inputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP controller whose TCK/TMS/TDI/TRSTn are oversampled by clk_i.
// TCK edges are found on the synchronized copy, so every TAP action lands
// three clk_i cycles after the raw TCK edge. USER_W must be at least 2.
module jtag_tap_oversampled
   import jtag_tap_pkg::*;
#(
   parameter logic [IDCODE_W-1:0] IDCODE = 32'h1000_0001,
   parameter int unsigned         USER_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tck_i,
   input  logic              tms_i,
   input  logic              tdi_i,
   input  logic              trst_ni,
   output logic              tdo_o,
   output logic              tdo_oe_o,
   input  logic [USER_W-1:0] user_rdata_i,
   output logic [USER_W-1:0] user_wdata_o,
   output logic              user_wvalid_o,
   output logic [3:0]        tap_state_o
);

   logic [3:0] sync_in;
   logic [3:0] sync_out;
   logic       trst_s;
   logic       tck_s;
   logic       tms_s;
   logic       tdi_s;

   assign sync_in = {trst_ni, tck_i, tms_i, tdi_i};

   jtag_sync #(
      .W       (4),
      .RST_VAL (4'b1110)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (sync_in),
      .q_o    (sync_out)
   );

   assign {trst_s, tck_s, tms_s, tdi_s} = sync_out;

   logic                tck_prev_q, tck_prev_d;
   tap_state_e          state_q, state_d;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic [IR_W-1:0]     ir_sr_q, ir_sr_d;
   logic [IDCODE_W-1:0] id_sr_q, id_sr_d;
   logic [USER_W-1:0]   user_sr_q, user_sr_d;
   logic                byp_q, byp_d;
   logic                tdo_q, tdo_d;
   logic                tdo_oe_q, tdo_oe_d;
   logic [USER_W-1:0]   user_wdata_q, user_wdata_d;
   logic                user_wvalid_q, user_wvalid_d;

   logic    tck_rise;
   logic    tck_fall;
   dr_sel_e dr_sel;
   logic    shift_lsb;

   assign tck_rise = tck_s & ~tck_prev_q;
   assign tck_fall = ~tck_s & tck_prev_q;
   assign dr_sel   = dr_decode(ir_q);

   // LSB of whichever register is currently shifting
   always_comb begin
      shift_lsb = 1'b0;
      if (state_q == SHIFT_IR) begin
         shift_lsb = ir_sr_q[0];
      end else if (state_q == SHIFT_DR) begin
         case (dr_sel)
            SEL_IDCODE: shift_lsb = id_sr_q[0];
            SEL_USER:   shift_lsb = user_sr_q[0];
            default:    shift_lsb = byp_q;
         endcase
      end
   end

   // TAP next-state, capture/shift/update and output next values
   always_comb begin
      tck_prev_d    = tck_s;
      state_d       = state_q;
      ir_d          = ir_q;
      ir_sr_d       = ir_sr_q;
      id_sr_d       = id_sr_q;
      user_sr_d     = user_sr_q;
      byp_d         = byp_q;
      tdo_d         = tdo_q;
      user_wdata_d  = user_wdata_q;
      user_wvalid_d = 1'b0;

      if (!trst_s) begin
         // TRST wins over any coincident TCK edge and drops partial scans
         state_d   = TEST_LOGIC_RESET;
         ir_d      = IR_IDCODE;
         ir_sr_d   = '0;
         id_sr_d   = '0;
         user_sr_d = '0;
         byp_d     = 1'b0;
      end else if (tck_rise) begin
         case (state_q)
            CAPTURE_IR: ir_sr_d = IR_CAPTURE;
            SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
            CAPTURE_DR: begin
               case (dr_sel)
                  SEL_IDCODE: id_sr_d   = IDCODE;
                  SEL_USER:   user_sr_d = user_rdata_i;
                  default:    byp_d     = 1'b0;
               endcase
            end
            SHIFT_DR: begin
               case (dr_sel)
                  SEL_IDCODE: id_sr_d   = {tdi_s, id_sr_q[IDCODE_W-1:1]};
                  SEL_USER:   user_sr_d = {tdi_s, user_sr_q[USER_W-1:1]};
                  default:    byp_d     = tdi_s;
               endcase
            end
            default: ;
         endcase
         state_d = tap_next(state_q, tms_s);
         if (state_d == TEST_LOGIC_RESET) begin
            ir_d = IR_IDCODE;
         end
      end else if (tck_fall) begin
         // Updates act on the falling edge while parked in Update-xR
         if (state_q == UPDATE_IR) begin
            ir_d = ir_sr_q;
         end else if ((state_q == UPDATE_DR) && (dr_sel == SEL_USER)) begin
            user_wdata_d  = user_sr_q;
            user_wvalid_d = 1'b1;
         end
      end

      tdo_oe_d = (state_d == SHIFT_IR) || (state_d == SHIFT_DR);
      if (!tdo_oe_d) begin
         tdo_d = 1'b0;
      end else if (tck_fall) begin
         tdo_d = shift_lsb;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tck_prev_q    <= 1'b1;
         state_q       <= TEST_LOGIC_RESET;
         ir_q          <= IR_IDCODE;
         ir_sr_q       <= '0;
         id_sr_q       <= '0;
         user_sr_q     <= '0;
         byp_q         <= 1'b0;
         tdo_q         <= 1'b0;
         tdo_oe_q      <= 1'b0;
         user_wdata_q  <= '0;
         user_wvalid_q <= 1'b0;
      end else begin
         tck_prev_q    <= tck_prev_d;
         state_q       <= state_d;
         ir_q          <= ir_d;
         ir_sr_q       <= ir_sr_d;
         id_sr_q       <= id_sr_d;
         user_sr_q     <= user_sr_d;
         byp_q         <= byp_d;
         tdo_q         <= tdo_d;
         tdo_oe_q      <= tdo_oe_d;
         user_wdata_q  <= user_wdata_d;
         user_wvalid_q <= user_wvalid_d;
      end
   end

   assign tdo_o         = tdo_q;
   assign tdo_oe_o      = tdo_oe_q;
   assign user_wdata_o  = user_wdata_q;
   assign user_wvalid_o = user_wvalid_q;
   assign tap_state_o   = state_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Scoreboard bench for jtag_tap_oversampled: a queue-based TAP model predicts
// TDO bits and USER writes; monitors compare whenever the DUT presents them.
module tb_jtag_tap_oversampled;

   localparam logic [31:0] IDCODE = 32'h1000_0001;
   localparam int          USER_W = 32;

   localparam logic [3:0] S_TLR  = 4'hF, S_RTI  = 4'hC, S_SDR  = 4'h7, S_CDR  = 4'h6;
   localparam logic [3:0] S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR  = 4'h3, S_E2DR = 4'h0;
   localparam logic [3:0] S_UDR  = 4'h5, S_SIR  = 4'h4, S_CIR  = 4'hE, S_SHIR = 4'hA;
   localparam logic [3:0] S_E1IR = 4'h9, S_PIR  = 4'hB, S_E2IR = 4'h8, S_UIR  = 4'hD;

   logic              clk_i;
   logic              rst_ni;
   logic              tck_i;
   logic              tms_i;
   logic              tdi_i;
   logic              trst_ni;
   logic              tdo_o;
   logic              tdo_oe_o;
   logic [USER_W-1:0] user_rdata_i;
   logic [USER_W-1:0] user_wdata_o;
   logic              user_wvalid_o;
   logic [3:0]        tap_state_o;

   jtag_tap_oversampled #(
      .IDCODE (IDCODE),
      .USER_W (USER_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .tck_i         (tck_i),
      .tms_i         (tms_i),
      .tdi_i         (tdi_i),
      .trst_ni       (trst_ni),
      .tdo_o         (tdo_o),
      .tdo_oe_o      (tdo_oe_o),
      .user_rdata_i  (user_rdata_i),
      .user_wdata_o  (user_wdata_o),
      .user_wvalid_o (user_wvalid_o),
      .tap_state_o   (tap_state_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   int wv_count = 0;

   // Reference model state
   logic [3:0]  m_state;
   logic [4:0]  m_ir;
   logic [31:0] m_wdata;
   bit          m_ir_sh[$];
   bit          m_dr_sh[$];
   bit          exp_tdo[$];
   logic [31:0] exp_w[$];
   bit          obs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [3:0] next_of(input logic [3:0] s, input bit tms);
      case (s)
         S_TLR:   return tms ? S_TLR  : S_RTI;
         S_RTI:   return tms ? S_SDR  : S_RTI;
         S_SDR:   return tms ? S_SIR  : S_CDR;
         S_CDR:   return tms ? S_E1DR : S_SHDR;
         S_SHDR:  return tms ? S_E1DR : S_SHDR;
         S_E1DR:  return tms ? S_UDR  : S_PDR;
         S_PDR:   return tms ? S_E2DR : S_PDR;
         S_E2DR:  return tms ? S_UDR  : S_SHDR;
         S_UDR:   return tms ? S_SDR  : S_RTI;
         S_SIR:   return tms ? S_TLR  : S_CIR;
         S_CIR:   return tms ? S_E1IR : S_SHIR;
         S_SHIR:  return tms ? S_E1IR : S_SHIR;
         S_E1IR:  return tms ? S_UIR  : S_PIR;
         S_PIR:   return tms ? S_E2IR : S_PIR;
         S_E2IR:  return tms ? S_UIR  : S_SHIR;
         default: return tms ? S_SDR  : S_RTI;
      endcase
   endfunction

   function automatic logic [63:0] obs_val();
      logic [63:0] v = '0;
      for (int i = 0; i < obs.size() && i < 64; i++) v[i] = obs[i];
      return v;
   endfunction

   // Model actions at a TCK rise: shift out/in, capture, advance state
   task automatic model_rise(input bit tms, input bit tdi);
      logic [31:0] val;
      int          len;
      bit          b;
      if (m_state == S_SHIR) begin
         b = (m_ir_sh.size() > 0) ? m_ir_sh.pop_front() : 1'b0;
         exp_tdo.push_back(b);
         m_ir_sh.push_back(tdi);
      end else if (m_state == S_SHDR) begin
         b = (m_dr_sh.size() > 0) ? m_dr_sh.pop_front() : 1'b0;
         exp_tdo.push_back(b);
         m_dr_sh.push_back(tdi);
      end else if (m_state == S_CIR) begin
         m_ir_sh.delete();
         for (int i = 0; i < 5; i++) m_ir_sh.push_back(i == 0);
      end else if (m_state == S_CDR) begin
         if (m_ir == 5'h01)      begin val = IDCODE;       len = 32;     end
         else if (m_ir == 5'h10) begin val = user_rdata_i; len = USER_W; end
         else                    begin val = '0;           len = 1;      end
         m_dr_sh.delete();
         for (int i = 0; i < len; i++) m_dr_sh.push_back(val[i]);
      end
      m_state = next_of(m_state, tms);
      if (m_state == S_TLR) m_ir = 5'h01;
   endtask

   // Model actions at a TCK fall: updates
   task automatic model_fall();
      logic [31:0] v;
      if (m_state == S_UIR) begin
         v = '0;
         for (int i = 0; i < 5 && i < m_ir_sh.size(); i++) v[i] = m_ir_sh[i];
         m_ir = v[4:0];
      end else if (m_state == S_UDR && m_ir == 5'h10) begin
         v = '0;
         for (int i = 0; i < USER_W && i < m_dr_sh.size(); i++) v[i] = m_dr_sh[i];
         m_wdata = v;
         exp_w.push_back(v);
      end
   endtask

   task automatic model_reset();
      m_state = S_TLR;
      m_ir    = 5'h01;
      m_ir_sh.delete();
      m_dr_sh.delete();
   endtask

   // TDO monitor: each rise in a Shift state consumes one predicted bit
   always @(posedge tck_i) begin
      if (rst_ni && tdo_oe_o) begin
         if (exp_tdo.size() == 0) begin
            n_checks++;
            $display("FAIL tdo_extra: got shift bit %0b with nothing expected at %0t", tdo_o, $time);
         end else begin
            obs.push_back(tdo_o);
            check("tdo", 64'(tdo_o), 64'(exp_tdo.pop_front()));
         end
      end
   end

   // USER write monitor
   always @(negedge clk_i) begin
      if (user_wvalid_o) begin
         wv_count++;
         if (exp_w.size() == 0) begin
            n_checks++;
            $display("FAIL wvalid_extra: got pulse data %0h with none expected at %0t", user_wdata_o, $time);
         end else begin
            check("user_wdata", 64'(user_wdata_o), 64'(exp_w.pop_front()));
         end
      end
   end

   task automatic tck_cycle(input bit tms, input bit tdi);
      @(negedge clk_i);
      tms_i = tms;
      tdi_i = tdi;
      repeat (5) @(negedge clk_i);
      model_rise(tms, tdi);
      tck_i = 1'b1;
      repeat (6) @(negedge clk_i);
      check("tap_state", 64'(tap_state_o), 64'(m_state));
      check("tdo_oe", 64'(tdo_oe_o), 64'((m_state == S_SHIR) || (m_state == S_SHDR)));
      tck_i = 1'b0;
      model_fall();
   endtask

   task automatic reset_tap();
      repeat (5) tck_cycle(1'b1, 1'b0);
      check("tlr_after_5_tms", 64'(tap_state_o), 64'(S_TLR));
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic load_ir(input logic [4:0] code);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      obs.delete();
      for (int i = 0; i < 5; i++) tck_cycle(i == 4, code[i]);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic scan_dr(input int n, input logic [63:0] data);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      obs.delete();
      for (int i = 0; i < n; i++) tck_cycle(i == n - 1, data[i]);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wv0;
      rst_ni       = 1'b0;
      tck_i        = 1'b0;
      tms_i        = 1'b1;
      tdi_i        = 1'b0;
      trst_ni      = 1'b1;
      user_rdata_i = '0;
      model_reset();
      m_wdata = '0;

      // Reset values
      repeat (3) @(negedge clk_i);
      check("rst_state", 64'(tap_state_o), 64'(S_TLR));
      check("rst_tdo", 64'(tdo_o), 64'(0));
      check("rst_tdo_oe", 64'(tdo_oe_o), 64'(0));
      check("rst_wdata", 64'(user_wdata_o), 64'(0));
      check("rst_wvalid", 64'(user_wvalid_o), 64'(0));
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);

      // IDCODE stream
      reset_tap();
      scan_dr(32, 64'(32'hFFFF_0000));
      check("idcode_stream", obs_val(), 64'(IDCODE));

      // Explicit BYPASS: 0 then A5 one bit late
      load_ir(5'h1F);
      scan_dr(9, 64'(9'h0A5));
      check("bypass_stream", obs_val(), 64'(9'h14A));

      // USER capture and update
      user_rdata_i = 32'hDEAD_BEEF;
      load_ir(5'h10);
      wv0 = wv_count;
      scan_dr(32, 64'(32'h1234_5678));
      check("user_capture", obs_val(), 64'(32'hDEAD_BEEF));
      repeat (4) @(negedge clk_i);
      check("user_wdata_hold", 64'(user_wdata_o), 64'(32'h1234_5678));
      check("user_wvalid_count", 64'(wv_count - wv0), 64'(1));

      // TRST mid Shift-DR with IR=USER
      wv0 = wv_count;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'b1);
      @(negedge clk_i);
      trst_ni = 1'b0;
      repeat (4) @(negedge clk_i);
      trst_ni = 1'b1;
      model_reset();
      repeat (4) @(negedge clk_i);
      check("trst_state", 64'(tap_state_o), 64'(S_TLR));
      check("trst_tdo_oe", 64'(tdo_oe_o), 64'(0));
      check("trst_wdata_kept", 64'(user_wdata_o), 64'(m_wdata));
      tck_cycle(1'b0, 1'b0);
      scan_dr(32, 64'(32'hA5A5_5A5A));
      check("trst_ir_idcode", obs_val(), 64'(IDCODE));
      check("trst_no_wvalid", 64'(wv_count - wv0), 64'(0));

      // Unknown IR code behaves as BYPASS
      load_ir(5'h07);
      check("capture_ir", obs_val(), 64'(5'b00001));
      scan_dr(2, 64'(2'b11));
      check("ir07_bypass", obs_val(), 64'(2'b10));

      // Randomized TMS/TDI walk
      for (int k = 0; k < 300; k++) begin
         user_rdata_i = $urandom;
         tck_cycle($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
      end
      reset_tap();

      // Async reset mid Shift-DR
      load_ir(5'h10);
      scan_dr(32, 64'(32'hCAFE_F00D));
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
      wv0 = wv_count;
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_state", 64'(tap_state_o), 64'(S_TLR));
      check("arst_tdo", 64'(tdo_o), 64'(0));
      check("arst_tdo_oe", 64'(tdo_oe_o), 64'(0));
      check("arst_wdata", 64'(user_wdata_o), 64'(0));
      check("arst_wvalid", 64'(user_wvalid_o), 64'(0));
      model_reset();
      m_wdata = '0;
      exp_tdo.delete();
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      tck_cycle(1'b0, 1'b0);
      scan_dr(32, 64'(32'h0));
      check("arst_ir_idcode", obs_val(), 64'(IDCODE));
      check("arst_no_wvalid", 64'(wv_count - wv0), 64'(0));

      repeat (6) @(negedge clk_i);
      check("tdo_queue_drained", 64'(exp_tdo.size()), 64'(0));
      check("wdata_queue_drained", 64'(exp_w.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
